// File: rtl/regfile_multiport_pkg.sv
// Shared definitions for the multi-read-port register file.
//   rf_state_t : sequencer state (idle / clear sweep in progress)
//   RF_DATA_W  : default register width
//   RF_ADDR_W  : default address width (depth = 2**RF_ADDR_W)
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus between decode/write-back and the register file.
//   we/waddr/wdata : write port, sampled on the rising clock edge
//   raddr/rdata    : NUM_RD read ports, packed; port k at [k*W +: W]
//   clr_req        : one-cycle request to clear the whole file
//   busy           : clear sweep in progress (reads forced to 0)
//   wr_err         : registered one-cycle pulse per dropped write
// Protocol: there is no valid/ready pair. A write is offered by holding
// we=1 for exactly one cycle; it is accepted on that edge unless busy=1,
// in which case it is dropped and wr_err answers one cycle later. Reads
// are purely combinational from raddr in the same cycle.
interface regfile_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       we;
    logic [ADDR_W-1:0]          waddr;
    logic [DATA_W-1:0]          wdata;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic                       clr_req;
    logic                       busy;
    logic                       wr_err;

    modport master (
        output we, waddr, wdata, raddr, clr_req,
        input  rdata, busy, wr_err
    );

    modport slave (
        input  we, waddr, wdata, raddr, clr_req,
        output rdata, busy, wr_err
    );
endinterface

// File: rtl/regfile_multiport_read_port.sv
// One combinational read port of the register file.
//   mem_i    : full register array
//   raddr_i  : read address
//   busy_i   : clear sweep in progress, forces the result to 0
//   we_i/waddr_i/wdata_i : write port, present only when
//              REGFILE_MULTIPORT_BYPASS_EN is defined (same-cycle bypass)
//   rdata_o  : read result
module regfile_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic [DATA_W-1:0] mem_i [DEPTH],
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              busy_i,
`ifdef REGFILE_MULTIPORT_BYPASS_EN
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
`endif
    output logic [DATA_W-1:0] rdata_o
);
    always_comb begin
        rdata_o = mem_i[raddr_i];
        // Priority order matters: busy wins over everything, then the
        // hardwired zero register, so bypass never leaks through either.
        if (busy_i) begin
            rdata_o = '0;
        end else if ((ZERO_REG != 0) && (raddr_i == '0)) begin
            rdata_o = '0;
        end
`ifdef REGFILE_MULTIPORT_BYPASS_EN
        else if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end
`endif
    end
endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file with NUM_RD combinational read ports, one
// write port and a sequenced clear engine.
//   clk, reset : clock; synchronous active-high reset (starts a clear sweep)
//   bus        : regfile_multiport_if slave (write, reads, clr_req, busy, wr_err)
//   state_o    : sequencer state, for observation
// Optional feature: define REGFILE_MULTIPORT_BYPASS_EN for same-cycle
// write-to-read bypass; otherwise reads see the stored value until the edge.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    regfile_multiport_if.slave bus,
    output rf_state_t         state_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    rf_state_t         state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              wr_err_q;
    logic              wr_block;

    // Writes to the hardwired zero register are silently ignored (no wr_err).
    assign wr_block = (ZERO_REG != 0) && (bus.waddr == '0);

    // Sequencer: sweep counter, state and the dropped-write pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RF_CLEAR;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            case (state_q)
                RF_IDLE: begin
                    wr_err_q <= 1'b0;
                    if (bus.clr_req) begin
                        state_q <= RF_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                RF_CLEAR: begin
                    // Every write offered during the sweep is dropped.
                    wr_err_q <= bus.we;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= RF_IDLE;
                    end
                end
                default: begin
                    state_q <= RF_CLEAR;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Storage: the array has no reset of its own; the sweep initialises it.
    // A write together with clr_req in IDLE commits here before the sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == RF_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else if (bus.we && !wr_block) begin
                mem_q[bus.waddr] <= bus.wdata;
            end
        end
    end

    assign bus.busy   = (state_q == RF_CLEAR);
    assign bus.wr_err = wr_err_q;
    assign state_o    = state_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .DEPTH   (DEPTH),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .mem_i   (mem_q),
            .raddr_i (bus.raddr[k*ADDR_W +: ADDR_W]),
            .busy_i  (bus.busy),
`ifdef REGFILE_MULTIPORT_BYPASS_EN
            .we_i    (bus.we),
            .waddr_i (bus.waddr),
            .wdata_i (bus.wdata),
`endif
            .rdata_o (bus.rdata[k*DATA_W +: DATA_W])
        );
    end
endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-read-port register file, the next generation of the processor's two-port register bank. It generalises data width, depth and read-port count, and hardwires register 0 to zero when configured. It adds a sequenced clear engine, with a busy indication, and optional same-cycle write-to-read bypass. It sits between decode (read addresses) and write-back (write port) in the datapath.

## Interface
- DATA_W, 32, data width of each register
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (≥1)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]; combinational from raddr
- clr_req  in  1  one-cycle request to clear the whole file
- busy  out  1  clear sweep in progress
- wr_err  out  1  registered one-cycle pulse: a write was dropped

## Operation
- States: IDLE, CLEAR. Sweep counter cnt is ADDR_W bits wide.
- Reset sampled high: state=CLEAR, cnt=0, wr_err=0. No array entry is written while reset is held.
- In CLEAR with reset low, each edge does the following:
  - clears entry cnt and increments cnt
  - at cnt==DEPTH-1, clears the last entry and moves to IDLE
  - cnt wraps to 0
- clr_req in IDLE: next state CLEAR, cnt=0. clr_req in CLEAR is ignored; the sweep is not restarted.
- Writes in IDLE: we=1 stores wdata at waddr on the edge.
  - With ZERO_REG=1 and waddr==0, nothing is stored and wr_err is not raised.
- Writes in CLEAR (we=1) are dropped; wr_err=1 on the next cycle.
- we=1 together with clr_req in IDLE: the write commits on that edge, then the sweep starts (and later erases it).
- Reads:
  - rdata port k = entry[raddr_k].
  - Forced to 0 while busy=1.
  - Forced to 0 when ZERO_REG=1 and raddr_k==0.
  - Ports are fully independent; identical addresses return identical data.

## Timing
- Reset values: busy=1, wr_err=0. rdata=0 (forced by busy).
- busy=1 combinationally whenever state==CLEAR.
- After reset deasserts, busy stays high for exactly DEPTH cycles.
- After clr_req in IDLE, busy rises the next cycle and stays high DEPTH cycles.
- Write latency: data written at edge N is visible on rdata in cycle N+1.
- Reset asserted mid-sweep: cnt returns to 0 and the sweep restarts after deassertion.
- A write in the same cycle reset is high is dropped without a wr_err pulse.
- wr_err is high one cycle per dropped write; back-to-back drops hold it high.

## Configuration
- Macro: REGFILE_MULTIPORT_BYPASS_EN.
- Defined: in IDLE, if we=1 and waddr==raddr_k, rdata port k returns wdata in the same cycle.
  - Excluded when ZERO_REG=1 and the address is 0.
  - Applies to each port independently.
- Undefined: rdata returns the stored (old) value until the edge.

## Structure
- Shared package regfile_pkg:
  - state enum rf_state_t {RF_IDLE, RF_CLEAR}
  - default width constants RF_DATA_W=32, RF_ADDR_W=5
- Sub-module regfile_read_port, one instance per read port via generate:
  - address mux over the array
  - busy/zero-register forcing
  - bypass compare (under the macro)
- Top level holds the array, the write port, the FSM, cnt and wr_err.

## Test plan
- Reset, then deassert with DEPTH=32 → busy high exactly 32 cycles; rdata=0 throughout; afterwards every address reads 0.
- Write 0xDEADBEEF to r5, then read r5 on ports 0 and 1 the next cycle → both 0xDEADBEEF. Write 0x1234 to r0 → r0 reads 0.
- Same-cycle write of 0xA5A5A5A5 to r7 while port 1 reads r7 → 0xA5A5A5A5 with the bypass macro defined, old value 0 without it.
- In IDLE, write r3=0x11, then clr_req; write r4=0x22 during the sweep → wr_err pulses 1 cycle; after busy falls, r3=0 and r4=0.
- Reset asserted at sweep cnt=10 for 2 cycles → busy remains high for 32 cycles after deassertion.
- NUM_RD=4, DATA_W=16: write r1..r4 with 0x0101·k, read them on ports 0..3 at once → each port returns its own value.
